instruction_fetch: RTL

- Fetch stage of the processor. It sits directly upstream of decode and of immediate_generator.
- Owns the PC and issues word fetches to instruction memory over a req/ready request channel with an in-order response channel.
- Buffers returned words and hands {pc, instr, instr_type} to decode on a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered words and discarding in-flight ones.
- instr_type uses the codes immediate_generator consumes.

---
 rtl/instruction_fetch_if.sv | 39 +++
 rtl/instruction_fetch.sv | 118 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// ============================================================================
// Module      : instruction_fetch_if
// Description : Fetch-stage bus bundle: imem request/response, redirect, decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [2:0]  if_instr_type;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output if_valid, if_pc, if_instr, if_instr_type,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  if_valid, if_pc, if_instr, if_instr_type,
        output if_ready
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : PC owner, credit-limited imem fetch, 2-entry buffer to decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    instruction_fetch_if.master bus
);

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    logic [31:0] r_pc;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_drop_cnt;
    logic [1:0]  r_count;
    logic [31:0] r_req_pc   [2];
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_instr[2];

    logic        w_head_valid;
    logic        w_pop;
    logic        w_credit;
    logic        w_req;
    logic        w_accept;
    logic        w_rsp;
    logic        w_drop;
    logic        w_push;
    logic        w_req_idx;
    logic        w_buf_idx;
    logic [31:0] w_redirect_target;
    logic [31:0] w_instr;
    logic [2:0]  w_type;

    assign w_head_valid = rst_n && (r_count != 2'd0);
    assign w_pop        = w_head_valid && bus.if_ready;
    // A same-cycle pop frees its slot, so it counts toward the issue credit.
    assign w_credit     = (({1'b0, r_outstanding} + {1'b0, r_count}) - {2'b00, w_pop}) < 3'd2;
    assign w_req        = rst_n && !bus.redirect_valid && w_credit;
    assign w_accept     = w_req && bus.imem_ready;
    assign w_rsp        = bus.imem_rvalid && (r_outstanding != 2'd0);
    assign w_drop       = w_rsp && (r_drop_cnt != 2'd0);
    assign w_push       = w_rsp && !w_drop && !bus.redirect_valid;

    assign w_req_idx    = (r_outstanding == 2'd2) || ((r_outstanding == 2'd1) && !w_rsp);
    assign w_buf_idx    = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);
    assign w_redirect_target = bus.redirect_pc & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= 2'd0;
            r_drop_cnt    <= 2'd0;
            r_count       <= 2'd0;
            r_req_pc[0]   <= 32'h0;
            r_req_pc[1]   <= 32'h0;
            r_buf_pc[0]   <= 32'h0;
            r_buf_pc[1]   <= 32'h0;
            r_buf_instr[0] <= c_NOP_INSTR;
            r_buf_instr[1] <= c_NOP_INSTR;
        end else begin
            r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_rsp};

            if (bus.redirect_valid) begin
                // Everything still in flight (minus a same-cycle response) is stale.
                r_pc       <= w_redirect_target;
                r_drop_cnt <= r_outstanding - {1'b0, w_rsp};
                r_count    <= 2'd0;
            end else begin
                if (w_accept) r_pc <= r_pc + 32'd4;
                if (w_drop)   r_drop_cnt <= r_drop_cnt - 2'd1;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end

            if (w_rsp)    r_req_pc[0] <= r_req_pc[1];
            if (w_accept) r_req_pc[w_req_idx] <= r_pc;

            if (w_pop) begin
                r_buf_pc[0]    <= r_buf_pc[1];
                r_buf_instr[0] <= r_buf_instr[1];
            end
            if (w_push) begin
                r_buf_pc[w_buf_idx]    <= r_req_pc[0];
                r_buf_instr[w_buf_idx] <= bus.imem_rdata;
            end
        end
    end

    assign w_instr = w_head_valid ? r_buf_instr[0] : c_NOP_INSTR;

    always_comb begin
        w_type = 3'b111;
        case (w_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_type = 3'b000;
            7'b0100011:                                     w_type = 3'b001;
            7'b0110111, 7'b0010111:                         w_type = 3'b010;
            7'b0110011:                                     w_type = 3'b011;
            7'b1100011:                                     w_type = 3'b101;
            7'b1101111:                                     w_type = 3'b110;
            default:                                        w_type = 3'b111;
        endcase
    end

    assign bus.imem_req      = w_req;
    assign bus.imem_addr     = r_pc;
    assign bus.if_valid      = w_head_valid;
    assign bus.if_pc         = w_head_valid ? r_buf_pc[0] : 32'h0;
    assign bus.if_instr      = w_instr;
    assign bus.if_instr_type = w_type;

endmodule

`default_nettype wire
